sdram_port_arbiter: RTL and testbench

//  Shares the single byte-wide SDRAM controller port between the HPS tape download

---
 rtl/sdram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one byte-wide SDRAM port between HPS download writes and cassette reads.
// Optional grant/defer statistics are enabled with SDRAM_ARB_STATS_EN.
module sdram_port_arbiter #(
  parameter int AW         = 25,
  parameter int ACC_CYCLES = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_wait,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [7:0]    mem_dout
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [31:0]   wr_count,
  output logic [31:0]   rd_count,
  output logic [15:0]   defer_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  localparam int CW = $clog2(ACC_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          wfull;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          rfull;
  logic [AW-1:0] raddr;
  logic          rd_inflight;
  logic          wr_grant;
  logic          rd_grant;

  // Writes win; reads also wait out an active download since SDRAM content is changing.
  assign wr_grant = (state == IDLE) && wfull;
  assign rd_grant = (state == IDLE) && !wfull && rfull && !dl_active;
  assign dl_wait  = wfull;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wfull       <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      rfull       <= 1'b0;
      raddr       <= '0;
      rd_inflight <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_we      <= 1'b0;
      mem_rd      <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      rd_valid <= 1'b0;

      if (dl_wr && !wfull) begin
        wfull <= 1'b1;
        waddr <= dl_addr;
        wdata <= dl_data;
      end

      // A new request landing on the grant edge stays buffered as the next one.
      if (rd_req) begin
        rfull <= 1'b1;
        raddr <= rd_addr;
      end else if (rd_grant) begin
        rfull <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wr_grant) begin
            state    <= WR;
            mem_we   <= 1'b1;
            mem_addr <= waddr;
            mem_din  <= wdata;
          end else if (rd_grant) begin
            state       <= RD;
            mem_rd      <= 1'b1;
            mem_addr    <= raddr;
            rd_inflight <= 1'b1;
          end
        end
        WR: begin
          wfull <= 1'b0;
          state <= WAIT;
          cnt   <= CW'(1);
        end
        RD: begin
          state <= WAIT;
          cnt   <= CW'(1);
        end
        default: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            if (rd_inflight) begin
              rd_data     <= mem_dout;
              rd_valid    <= 1'b1;
              rd_inflight <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  // Saturating counters of grants and of cycles a pending read was held off.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_count    <= '0;
      rd_count    <= '0;
      defer_count <= '0;
    end else begin
      if (wr_grant && (wr_count != '1))
        wr_count <= wr_count + 32'd1;
      if (rd_grant && (rd_count != '1))
        rd_count <= rd_count + 32'd1;
      if (rfull && (dl_active || wfull) && (defer_count != '1))
        defer_count <= defer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small byte-wide SDRAM model.
// Stats checks are compiled in when SDRAM_ARB_STATS_EN is defined.
module tb_sdram_port_arbiter;

  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          dl_active;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_wait;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [7:0]    mem_dout;
`ifdef SDRAM_ARB_STATS_EN
  logic [31:0]   wr_count;
  logic [31:0]   rd_count;
  logic [15:0]   defer_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:255];

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter #(.AW(AW), .ACC_CYCLES(8)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_wait    (dl_wait),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .mem_dout   (mem_dout)
`ifdef SDRAM_ARB_STATS_EN
    ,
    .wr_count   (wr_count),
    .rd_count   (rd_count),
    .defer_count(defer_count)
`endif
  );

  // SDRAM model: read data appears the cycle after the read command.
  always @(posedge clk_sys) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_din;
    if (mem_rd) mem_dout <= mem[mem_addr[7:0]];
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int m;
    int rd_cnt;
    int val_cnt;
    logic [AW-1:0] last_rd_addr;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem_dout  = 8'h00;
    reset_n   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    rd_req    = 1'b0;
    rd_addr   = '0;
    tick();
    tick();
    check("rst_dl_wait",  32'(dl_wait),  32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_data",  32'(rd_data),  32'h0);
    check("rst_mem_we",   32'(mem_we),   32'h0);
    check("rst_mem_rd",   32'(mem_rd),   32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_din",  32'(mem_din),  32'h0);
    reset_n = 1'b1;
    tick();

    // Single write
    dl_wr = 1'b1; dl_addr = 25'h10; dl_data = 8'hA5;
    tick();
    dl_wr = 1'b0;
    check("wr_wait_rise", 32'(dl_wait), 32'h1);
    check("wr_no_we_yet", 32'(mem_we),  32'h0);
    tick();
    check("wr_we",        32'(mem_we),   32'h1);
    check("wr_addr",      32'(mem_addr), 32'h10);
    check("wr_din",       32'(mem_din),  32'hA5);
    check("wr_wait_hold", 32'(dl_wait),  32'h1);
    tick();
    check("wr_we_pulse",  32'(mem_we),  32'h0);
    check("wr_wait_fall", 32'(dl_wait), 32'h0);
    repeat (8) tick();

    // Read from idle: rd_valid 10 cycles after rd_req
    rd_req = 1'b1; rd_addr = 25'h10;
    tick();
    rd_req = 1'b0;
    n = 1;
    while (!rd_valid && n < 20) begin tick(); n++; end
    check("rd_latency", 32'(n),       32'd10);
    check("rd_data",    32'(rd_data), 32'hA5);
    tick();
    check("rd_valid_pulse", 32'(rd_valid), 32'h0);
    check("rd_data_hold",   32'(rd_data),  32'hA5);
    repeat (2) tick();

    // Simultaneous write and read: write first, read 9 cycles later
    dl_wr = 1'b1; dl_addr = 25'h40; dl_data = 8'h3C;
    rd_req = 1'b1; rd_addr = 25'h40;
    tick();
    dl_wr = 1'b0; rd_req = 1'b0;
    n = 1;
    while (!mem_we && !mem_rd && n < 20) begin tick(); n++; end
    check("sim_we_first", 32'(mem_we), 32'h1);
    check("sim_we_cycle", 32'(n),      32'd2);
    m = 0;
    tick(); m++;
    while (!mem_rd && m < 20) begin tick(); m++; end
    check("sim_rd_spacing", 32'(m),        32'd9);
    check("sim_rd_addr",    32'(mem_addr), 32'h40);
    n = 0;
    while (!rd_valid && n < 20) begin tick(); n++; end
    check("sim_rd_data", 32'(rd_data), 32'h3C);
    repeat (2) tick();

    // Reads deferred during download
    dl_active = 1'b1;
    rd_req = 1'b1; rd_addr = 25'h20;
    tick();
    rd_req = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_rd) rd_cnt++;
      tick();
    end
    check("defer_no_rd", 32'(rd_cnt), 32'd0);
    dl_active = 1'b0;
    n = 0;
    while (!mem_rd && n < 2) begin tick(); n++; end
    check("defer_rd_issue", 32'(mem_rd),   32'h1);
    check("defer_rd_addr",  32'(mem_addr), 32'h20);
    n = 0;
    while (!rd_valid && n < 20) begin tick(); n++; end
    check("defer_rd_data", 32'(rd_data), 32'h7A);
    repeat (2) tick();

    // Newest read request wins while busy
    dl_wr = 1'b1; dl_addr = 25'h50; dl_data = 8'h11;
    tick();
    dl_wr = 1'b0;
    rd_req = 1'b1; rd_addr = 25'h30;
    tick();
    rd_addr = 25'h31;
    tick();
    rd_req = 1'b0;
    rd_cnt = 0; val_cnt = 0; last_rd_addr = '0;
    for (int i = 0; i < 40; i++) begin
      if (mem_rd) begin rd_cnt++; last_rd_addr = mem_addr; end
      if (rd_valid) val_cnt++;
      tick();
    end
    check("ovw_rd_count",    32'(rd_cnt),       32'd1);
    check("ovw_rd_addr",     32'(last_rd_addr), 32'h31);
    check("ovw_valid_count", 32'(val_cnt),      32'd1);
    check("ovw_rd_data",     32'(rd_data),      32'h6B);

    // Reset during the WAIT of a read
    rd_req = 1'b1; rd_addr = 25'h10;
    tick();
    rd_req = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("rstw_rd_data",  32'(rd_data),  32'h0);
    check("rstw_mem_addr", 32'(mem_addr), 32'h0);
    check("rstw_mem_din",  32'(mem_din),  32'h0);
    check("rstw_dl_wait",  32'(dl_wait),  32'h0);
    check("rstw_mem_rd",   32'(mem_rd),   32'h0);
    tick();
    reset_n = 1'b1;
    rd_cnt = 0; val_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd) rd_cnt++;
      if (rd_valid) val_cnt++;
      tick();
    end
    check("rstw_no_valid", 32'(val_cnt), 32'd0);
    check("rstw_no_rd",    32'(rd_cnt),  32'd0);

`ifdef SDRAM_ARB_STATS_EN
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      dl_wr = 1'b1; dl_addr = 25'(8'h60 + i); dl_data = 8'(i);
      tick();
      dl_wr = 1'b0;
      repeat (12) tick();
    end
    for (int i = 0; i < 2; i++) begin
      rd_req = 1'b1; rd_addr = 25'(8'h60 + i);
      tick();
      rd_req = 1'b0;
      repeat (12) tick();
    end
    check("stat_wr_count",    wr_count,          32'd4);
    check("stat_rd_count",    rd_count,          32'd2);
    check("stat_defer_count", 32'(defer_count),  32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
